coco_timer: RTL and testbench

//  Memory-mapped down-counting timer: the device/responder end of the system bridge's DEVx bus.
//  Two instances are used:
//   - DEV0 at 0x7F00-0x7F0B;
//   - DEV1 at 0x7F10-0x7F1B.

---
 rtl/coco_timer.sv | 118 +++++++++++
 tb/tb_coco_timer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/coco_timer.sv
// coco_timer: memory-mapped down-counting timer.
// This is the responder end of one DEVx port on the system bridge. The bridge
// has already decoded the address, so this block only looks at Addr[3:2].
//
// Ports
//   clk      system clock; all state changes on the rising edge
//   reset_n  asynchronous active-low reset
//   Addr     word address [31:2]; only Addr[3:2] (Addr[1:0] here) is decoded
//   WD       write data
//   WE       write enable, already qualified by the bridge decode
//   RD       read data, combinational from Addr[3:2]
//   IRQ      interrupt request toward the bridge
//
// Register map (Addr[3:2])
//   00 CTRL   {28'b0, IM, MODE[1:0], EN}
//   01 PRESET read/write
//   10 COUNT  read-only
//   11        reads 0
module coco_timer #(
  parameter logic [31:0] PRESET_RST = 32'h0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [29:0] Addr,
  input  logic [31:0] WD,
  input  logic        WE,
  output logic [31:0] RD,
  output logic        IRQ
);

  typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;

  typedef struct packed {
    logic       im;
    logic [1:0] mode;
    logic       en;
  } ctrl_t;

  localparam logic [1:0] MODE_RELOAD = 2'b01;

  state_t      state;
  ctrl_t       ctrl;
  logic [31:0] preset;
  logic [31:0] count;
  logic        irq_pend;

  logic        wr_ctrl;
  logic        wr_preset;
  logic        auto_reload;
  logic        unused_addr;

  assign wr_ctrl     = WE && (Addr[1:0] == 2'b00);
  assign wr_preset   = WE && (Addr[1:0] == 2'b01);
  // Modes 10 and 11 behave as one-shot.
  assign auto_reload = (ctrl.mode == MODE_RELOAD);
  // Upper address bits are decoded by the bridge, not here.
  assign unused_addr = ^Addr[29:2];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      ctrl     <= '0;
      preset   <= PRESET_RST;
      count    <= '0;
      irq_pend <= 1'b0;
    end else begin
      if (wr_preset) preset <= WD;
      // Any CPU write to CTRL/PRESET acknowledges a pending interrupt; an
      // expiry on the same edge re-sets it below and takes priority.
      if (wr_ctrl || wr_preset) irq_pend <= 1'b0;

      case (state)
        IDLE: if (ctrl.en) state <= LOAD;
        // LOAD always takes PRESET, so re-enable never resumes a frozen COUNT.
        LOAD: begin
          count <= preset;
          state <= CNT;
        end
        CNT: begin
          if (!ctrl.en) begin
            state <= IDLE;                  // COUNT frozen at current value
          end else if (count > 32'd1) begin
            count <= count - 32'd1;
          end else begin
            count <= '0;                    // PRESET=0 expires like PRESET=1
            state <= INT;
          end
        end
        INT: begin
          if (auto_reload) begin
            state <= LOAD;
          end else begin
            ctrl.en  <= 1'b0;
            irq_pend <= 1'b1;
            state    <= IDLE;
          end
        end
      endcase

      // Placed last so a CPU write to CTRL overrides the one-shot EN clear.
      if (wr_ctrl) ctrl <= ctrl_t'(WD[3:0]);
    end
  end

  always_comb begin
    RD = '0;
    case (Addr[1:0])
      2'b00:   RD = {28'b0, ctrl};
      2'b01:   RD = preset;
      2'b10:   RD = count;
      default: RD = '0;
    endcase
  end

  // Auto-reload has no pending flag; it pulses for the single INT cycle.
  assign IRQ = ctrl.im && (irq_pend || ((state == INT) && auto_reload));

endmodule

// File: tb/tb_coco_timer.sv
// Scoreboard bench for coco_timer. The driver computes the expected RD/IRQ
// from a behavioural model and queues it; a monitor pops and compares every
// cycle. A few latency/period properties are also checked directly.
module tb_coco_timer;

  localparam logic [31:0] PRST = 32'h0000_0003;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [29:0] Addr;
  logic [31:0] WD;
  logic        WE;
  logic [31:0] RD;
  logic        IRQ;

  coco_timer #(.PRESET_RST(PRST)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .Addr   (Addr),
    .WD     (WD),
    .WE     (WE),
    .RD     (RD),
    .IRQ    (IRQ)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rd;
    logic        irq;
    int          tag;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Behavioural model. Phase: 0 idle, 1 loading, 2 counting, 3 expired.
  int          ph;
  bit          m_en, m_im;
  bit [1:0]    m_mode;
  bit [31:0]   m_preset, m_count;
  bit          m_pend;

  function automatic void m_reset();
    ph = 0; m_en = 0; m_im = 0; m_mode = 0;
    m_preset = PRST; m_count = 0; m_pend = 0;
  endfunction

  function automatic logic [31:0] m_rd(input logic [1:0] a);
    case (a)
      2'd0:    return {28'b0, m_im, m_mode, m_en};
      2'd1:    return m_preset;
      2'd2:    return m_count;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic m_irq();
    return m_im && (m_pend || (ph == 3 && m_mode == 2'b01));
  endfunction

  function automatic void m_step(input logic we, input logic [1:0] a, input logic [31:0] wd);
    int        nph   = ph;
    bit [31:0] ncnt  = m_count;
    bit        nen   = m_en;
    bit        setp  = 0;
    bit        wr_c  = we && (a == 2'd0);
    bit        wr_p  = we && (a == 2'd1);
    if (ph == 0) begin
      if (m_en) nph = 1;
    end else if (ph == 1) begin
      ncnt = m_preset; nph = 2;
    end else if (ph == 2) begin
      if (!m_en) nph = 0;
      else if (m_count > 1) ncnt = m_count - 1;
      else begin ncnt = 0; nph = 3; end
    end else begin
      if (m_mode == 2'b01) nph = 1;
      else begin nen = 0; setp = 1; nph = 0; end
    end
    if (setp) m_pend = 1;
    else if (wr_c || wr_p) m_pend = 0;
    if (wr_p) m_preset = wd;
    if (wr_c) begin m_im = wd[3]; m_mode = wd[2:1]; nen = wd[0]; end
    ph = nph; m_count = ncnt; m_en = nen;
  endfunction

  task automatic cycle(input logic we, input logic [1:0] a, input logic [31:0] wd,
                       input bit rst, input int tag);
    exp_t        e;
    logic [29:0] hi;
    @(negedge clk);
    hi   = 30'($urandom());
    WE   = we;
    Addr = {hi[29:2], a};
    WD   = wd;
    if (rst) begin reset_n = 1'b0; m_reset(); end
    e.rd = m_rd(a); e.irq = m_irq(); e.tag = tag;
    sbq.push_back(e);
    @(posedge clk);
    if (rst) #1 reset_n = 1'b1;
    else m_step(we, a, wd);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] wd, input int tag);
    cycle(1'b1, a, wd, 1'b0, tag);
  endtask

  task automatic rd(input logic [1:0] a, input int tag);
    cycle(1'b0, a, 32'd0, 1'b0, tag);
  endtask

  task automatic dchk(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, required %0d", name, act, req);
  endtask

  // Cycles after the last call until IRQ is first seen high; -1 if never.
  task automatic wait_irq(input int budget, input int tag, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      rd(2'd2, tag);
      #1;
      if (IRQ === 1'b1) begin n = i; break; end
    end
  endtask

  // Monitor: compares one queued expectation per cycle, mid-low-phase.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        n_checks++;
        if (RD === e.rd && IRQ === e.irq) n_pass++;
        else $display("FAIL sb tag=%0d: RD=%h IRQ=%b, required RD=%h IRQ=%b",
                      e.tag, RD, IRQ, e.rd, e.irq);
      end
    end
  end

  initial begin
    int n, prev_rise, rises;
    bit found;
    reset_n = 1'b0; WE = 1'b0; Addr = '0; WD = '0;
    m_reset();

    // Reset state
    cycle(1'b0, 2'd0, 32'd0, 1'b1, 1);
    cycle(1'b0, 2'd1, 32'd0, 1'b1, 2);
    cycle(1'b0, 2'd2, 32'd0, 1'b1, 3);
    for (int i = 0; i < 4; i++) rd(2'(i), 4);

    // One-shot, PRESET=5: IRQ rises 8 edges after the CTRL write
    wr(2'd1, 32'd5, 10);
    wr(2'd0, 32'h9, 11);
    wait_irq(30, 12, n);
    dchk("oneshot_latency", n, 8);
    rd(2'd2, 13); rd(2'd0, 14);
    for (int i = 0; i < 4; i++) rd(2'd0, 15);
    wr(2'd0, 32'h8, 16);
    rd(2'd0, 17); rd(2'd2, 17);
    #1 dchk("pend_cleared", int'(IRQ), 0);

    // Auto-reload, PRESET=3: one-cycle pulses every 5 cycles
    wr(2'd1, 32'd3, 20);
    wr(2'd0, 32'hB, 21);
    prev_rise = -1; rises = 0;
    for (int i = 1; i <= 24; i++) begin
      rd(2'd2, 22);
      #1;
      if (IRQ === 1'b1) begin
        if (prev_rise >= 0) dchk("reload_period", i - prev_rise, 5);
        prev_rise = i; rises++;
      end
    end
    dchk("reload_rises", int'(rises >= 4), 1);
    wr(2'd0, 32'h0, 23);
    for (int i = 0; i < 5; i++) rd(2'd2, 24);

    // PRESET=0 behaves as PRESET=1
    wr(2'd1, 32'd0, 30);
    wr(2'd0, 32'h9, 31);
    wait_irq(20, 32, n);
    dchk("preset0_latency", n, 4);
    wr(2'd0, 32'h0, 33);
    for (int i = 0; i < 3; i++) rd(2'd0, 34);

    // Disable mid-count so COUNT freezes at 7, then re-enable reloads
    wr(2'd1, 32'd20, 40);
    wr(2'd0, 32'h9, 41);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      rd(2'd2, 42);
      if (ph == 2 && m_count == 8) found = 1;
    end
    dchk("reach_count8", int'(found), 1);
    wr(2'd0, 32'h8, 43);
    for (int i = 0; i < 5; i++) rd(2'd2, 44);
    #1 dchk("frozen_count", int'(RD), 7);
    wr(2'd0, 32'h9, 45);
    for (int i = 0; i < 3; i++) rd(2'd2, 46);
    wr(2'd0, 32'h0, 47);
    for (int i = 0; i < 3; i++) rd(2'd2, 48);

    // One-shot with IM=0: pending but masked, then cleared by CTRL write
    wr(2'd1, 32'd2, 50);
    wr(2'd0, 32'h1, 51);
    for (int i = 0; i < 8; i++) rd(2'd0, 52);
    wr(2'd0, 32'h8, 53);
    for (int i = 0; i < 3; i++) rd(2'd0, 54);

    // PRESET rewritten during counting only affects the next load
    wr(2'd1, 32'd6, 60);
    wr(2'd0, 32'hB, 61);
    for (int i = 0; i < 4; i++) rd(2'd2, 62);
    wr(2'd1, 32'd2, 63);
    for (int i = 0; i < 14; i++) rd(2'(i % 3), 64);
    wr(2'd0, 32'h0, 65);
    for (int i = 0; i < 4; i++) rd(2'd2, 66);

    // CTRL write on the edge where one-shot expiry clears EN
    wr(2'd1, 32'd2, 70);
    wr(2'd0, 32'h9, 71);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      rd(2'd2, 72);
      if (ph == 3) found = 1;
    end
    dchk("reach_int", int'(found), 1);
    wr(2'd0, 32'h9, 73);
    for (int i = 0; i < 6; i++) rd(2'(i % 3), 74);
    wr(2'd0, 32'h0, 75);
    for (int i = 0; i < 3; i++) rd(2'd0, 76);

    // Asynchronous reset mid-count
    wr(2'd1, 32'd10, 80);
    wr(2'd0, 32'hB, 81);
    for (int i = 0; i < 4; i++) rd(2'd2, 82);
    cycle(1'b0, 2'd2, 32'd0, 1'b1, 83);
    rd(2'd0, 84); rd(2'd1, 84); rd(2'd2, 84);

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      int r = $urandom_range(0, 99);
      if (r < 8)       wr(2'd0, 32'($urandom_range(0, 15)), 100);
      else if (r < 14) wr(2'd1, 32'($urandom_range(0, 7)), 101);
      else if (r < 17) wr(2'($urandom_range(2, 3)), $urandom(), 102);
      else if (r < 18) cycle(1'b0, 2'($urandom_range(0, 3)), 32'd0, 1'b1, 103);
      else             rd(2'($urandom_range(0, 3)), 104);
    end

    @(negedge clk); #4;
    n_checks++;
    if (sbq.size() == 0) n_pass++;
    else $display("FAIL sb_drain: %0d left, required 0", sbq.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
